wmem_ctrl: RTL and testbench

Sequencing controller for the weight memory that feeds the MAC cluster. In LOAD mode it packs a narrow weight stream into full memory lines and writes them to consecutive addresses. In RUN mode it issues a contiguous block of line reads to the memory, optionally repeated, under MAC back-pressure. It sits between the host/DMA weight stream and the weight-memory write/read ports, and it owns both ports exclusively.

---
 rtl/wmem_ctrl.sv | 152 +++++++++++++++
 tb/tb_wmem_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wmem_ctrl.sv
// Weight-memory sequencer: packs the narrow weight stream into lines on LOAD,
// and streams contiguous line reads to the MAC cluster on RUN.
module wmem_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_MAC4   = 16,
  parameter int ADDR_WIDTH = 7,
  parameter int BUS_WIDTH  = 32,
  parameter int LINE_WIDTH = NUM_MAC4*4*DATA_WIDTH,
  parameter int BEATS      = LINE_WIDTH/BUS_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_load_start,
  input  logic                  in_run_start,
  input  logic [ADDR_WIDTH-1:0] in_cfg_base,
  input  logic [ADDR_WIDTH-1:0] in_cfg_len,
  input  logic [7:0]            in_cfg_repeat,
  input  logic                  in_s_valid,
  input  logic [BUS_WIDTH-1:0]  in_s_data,
  output logic                  out_s_ready,
  output logic                  out_wr_en,
  output logic [ADDR_WIDTH-1:0] out_wr_addr,
  output logic [LINE_WIDTH-1:0] out_wr_data,
  output logic                  out_rd_en,
  output logic [ADDR_WIDTH-1:0] out_rd_addr,
  input  logic                  in_mac_ready,
  output logic                  out_busy,
  output logic                  out_done
);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_RUN, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [ADDR_WIDTH:0]   line_q, line_d;
  logic [7:0]            pass_q, pass_d;
  logic [7:0]            rep_q, rep_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] buf_q, buf_d;

  logic [ADDR_WIDTH:0]   line_inc;
  logic [7:0]            pass_inc;
  logic                  last_line;

  assign line_inc  = line_q + 1'b1;
  assign pass_inc  = pass_q + 8'd1;
  assign last_line = (line_inc == {1'b0, len_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      line_q <= '0;
      pass_q <= '0;
      rep_q  <= '0;
      base_q <= '0;
      len_q  <= '0;
      addr_q <= '0;
      buf_q  <= '0;
    end else begin
      beat_q <= beat_d;
      line_q <= line_d;
      pass_q <= pass_d;
      rep_q  <= rep_d;
      base_q <= base_d;
      len_q  <= len_d;
      addr_q <= addr_d;
      buf_q  <= buf_d;
    end
  end

  // addr_q is the single line pointer shared by both ports; only one port is live per state
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    line_d  = line_q;
    pass_d  = pass_q;
    rep_d   = rep_q;
    base_d  = base_q;
    len_d   = len_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_load_start || in_run_start) begin
          base_d = in_cfg_base;
          len_d  = in_cfg_len;
          addr_d = in_cfg_base;
          line_d = '0;
          beat_d = '0;
          pass_d = '0;
          if (in_load_start) begin
            state_d = (in_cfg_len == '0) ? S_DONE : S_LOAD;
          end else begin
            rep_d   = (in_cfg_repeat == 8'd0) ? 8'd1 : in_cfg_repeat;
            state_d = (in_cfg_len == '0) ? S_DONE : S_RUN;
          end
        end
      end
      S_LOAD: begin
        if (in_s_valid) begin
          buf_d[int'(beat_q)*BUS_WIDTH +: BUS_WIDTH] = in_s_data;
          beat_d = beat_q + 1'b1;
          if (beat_q == BW'(BEATS-1)) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        line_d  = line_inc;
        addr_d  = addr_q + 1'b1;
        beat_d  = '0;
        state_d = last_line ? S_DONE : S_LOAD;
      end
      S_RUN: begin
        if (in_mac_ready) begin
          if (last_line) begin
            pass_d = pass_inc;
            if (pass_inc >= rep_q) begin
              state_d = S_DONE;
            end else begin
              line_d = '0;
              addr_d = base_q;
            end
          end else begin
            line_d = line_inc;
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_s_ready = (state_q == S_LOAD);
    out_wr_en   = (state_q == S_WRITE);
    out_rd_en   = (state_q == S_RUN);
    out_busy    = (state_q != S_IDLE);
    out_done    = (state_q == S_DONE);
    out_wr_addr = addr_q;
    out_rd_addr = addr_q;
    out_wr_data = buf_q;
  end

endmodule

// File: tb/tb_wmem_ctrl.sv
// Bench for wmem_ctrl: scenario table plus random ops, scored against a
// line-level model of the expected write and consumed-read sequences.
module tb_wmem_ctrl;
  localparam int A      = 7;
  localparam int BUSW   = 32;
  localparam int LINEW  = 512;
  localparam int BEATS  = LINEW/BUSW;
  localparam int BUDGET = 3000;

  logic             clk, rst_n;
  logic             in_load_start, in_run_start;
  logic [A-1:0]     in_cfg_base, in_cfg_len;
  logic [7:0]       in_cfg_repeat;
  logic             in_s_valid;
  logic [BUSW-1:0]  in_s_data;
  logic             out_s_ready, out_wr_en, out_rd_en, in_mac_ready, out_busy, out_done;
  logic [A-1:0]     out_wr_addr, out_rd_addr;
  logic [LINEW-1:0] out_wr_data;

  int n_cmp = 0;
  int n_fail = 0;

  wmem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_load_start(in_load_start), .in_run_start(in_run_start),
    .in_cfg_base(in_cfg_base), .in_cfg_len(in_cfg_len), .in_cfg_repeat(in_cfg_repeat),
    .in_s_valid(in_s_valid), .in_s_data(in_s_data), .out_s_ready(out_s_ready),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
    .out_rd_en(out_rd_en), .out_rd_addr(out_rd_addr), .in_mac_ready(in_mac_ready),
    .out_busy(out_busy), .out_done(out_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string nm;
    bit    load;      // 1: load_start, 0: run_start
    bit    both;      // pulse both starts together
    int    base, len, rep;
    int    vpct;      // stream valid probability, percent
    int    stall;     // 0 always ready, 1 low every third cycle, 2 random
    bit    seqdata;   // stream words 0,1,2,...
    int    busy_start;// cycle of an extra start pulse while busy (-1 none)
    int    exp_wr, exp_rd, exp_done; // -1 = not fixed by the table
  } vec_t;

  function automatic vec_t mk(string nm, bit load, bit both, int base, int len, int rep,
                              int vpct, int stall, bit seqdata, int bs,
                              int ew, int er, int ed);
    vec_t v;
    v.nm = nm; v.load = load; v.both = both; v.base = base; v.len = len; v.rep = rep;
    v.vpct = vpct; v.stall = stall; v.seqdata = seqdata; v.busy_start = bs;
    v.exp_wr = ew; v.exp_rd = er; v.exp_done = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [LINEW-1:0] act, input logic [LINEW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v);
    logic [BUSW-1:0]  words[$];
    logic [LINEW-1:0] wr_data[$];
    int               wr_addr[$];
    int               rd_addr[$];
    int               exp_rd[$];
    logic [LINEW-1:0] line;
    int idx, nacc, ndone, done_cyc, first_act, last_act, prev_addr, passes, nwords;
    bit is_load, v_excl, v_wrrdy, v_hold, busy_late, prev_stall;
    is_load = v.load || v.both;
    nwords  = is_load ? v.len*BEATS : 0;
    for (int i = 0; i < nwords; i++) words.push_back(v.seqdata ? 32'(i) : $urandom);
    idx = 0; nacc = 0; ndone = 0; done_cyc = -1; first_act = -1; last_act = -1;
    prev_addr = 0; prev_stall = 0; v_excl = 0; v_wrrdy = 0; v_hold = 0; busy_late = 0;

    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(posedge clk); #1;
      in_load_start = 1'b0; in_run_start = 1'b0;
      in_cfg_base = A'($urandom); in_cfg_len = A'($urandom); in_cfg_repeat = 8'($urandom);
      if (cyc == 0) begin
        in_load_start = is_load;
        in_run_start  = !v.load || v.both;
        in_cfg_base = A'(v.base); in_cfg_len = A'(v.len); in_cfg_repeat = 8'(v.rep);
      end else if (cyc == v.busy_start) begin
        in_load_start = 1'b1; in_run_start = 1'b1;
        in_cfg_base = A'(v.base + 7); in_cfg_len = 7'd1;
      end
      in_s_valid   = (idx < nwords) && ($urandom_range(99) < v.vpct);
      in_s_data    = (idx < nwords) ? words[idx] : $urandom;
      in_mac_ready = (v.stall == 0) ? 1'b1 : (v.stall == 1) ? (cyc % 3 != 2) : ($urandom_range(3) != 0);
      @(negedge clk);
      if (out_wr_en && out_rd_en)   v_excl  = 1;
      if (out_wr_en && out_s_ready) v_wrrdy = 1;
      if (prev_stall && out_rd_en && int'(out_rd_addr) != prev_addr) v_hold = 1;
      prev_stall = out_rd_en && !in_mac_ready;
      prev_addr  = int'(out_rd_addr);
      if (out_wr_en) begin wr_addr.push_back(int'(out_wr_addr)); wr_data.push_back(out_wr_data); last_act = cyc; end
      if (out_rd_en && in_mac_ready) begin rd_addr.push_back(int'(out_rd_addr)); last_act = cyc; end
      if (in_s_valid && out_s_ready) begin nacc++; idx++; end
      if ((out_s_ready || out_rd_en) && first_act < 0) first_act = cyc;
      if (out_done) begin ndone++; if (done_cyc < 0) done_cyc = cyc; end
      if (done_cyc >= 0 && cyc == done_cyc + 1 && out_busy) busy_late = 1;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    in_s_valid = 1'b0; in_mac_ready = 1'b0;

    if (done_cyc < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: no done within %0d cycles", v.nm, BUDGET);
      return;
    end

    // reference: line i at (base+i) mod 128 holds words i*BEATS..; reads repeat the block
    passes = (v.rep == 0) ? 1 : v.rep;
    if (!is_load) for (int p = 0; p < passes; p++) for (int i = 0; i < v.len; i++)
      exp_rd.push_back((v.base + i) % (1 << A));

    chk({v.nm, "_done_cnt"}, ndone, 1);
    chk({v.nm, "_accepted"}, nacc, nwords);
    chk({v.nm, "_wr_cnt"}, wr_addr.size(), is_load ? v.len : 0);
    chk({v.nm, "_rd_cnt"}, rd_addr.size(), exp_rd.size());
    if (v.exp_wr >= 0) chk({v.nm, "_wr_cnt_tbl"}, wr_addr.size(), v.exp_wr);
    if (v.exp_rd >= 0) chk({v.nm, "_rd_cnt_tbl"}, rd_addr.size(), v.exp_rd);
    if (v.exp_done >= 0) chk({v.nm, "_done_cyc"}, done_cyc, v.exp_done);
    for (int i = 0; i < wr_addr.size() && i < v.len && is_load; i++) begin
      for (int k = 0; k < BEATS; k++) line[k*BUSW +: BUSW] = words[i*BEATS + k];
      chk($sformatf("%s_wr_addr%0d", v.nm, i), wr_addr[i], (v.base + i) % (1 << A));
      chk($sformatf("%s_wr_data%0d", v.nm, i), wr_data[i], line);
    end
    for (int i = 0; i < rd_addr.size() && i < exp_rd.size(); i++)
      chk($sformatf("%s_rd_addr%0d", v.nm, i), rd_addr[i], exp_rd[i]);
    if (v.len > 0) begin
      chk({v.nm, "_first_active"}, first_act, 1);
      chk({v.nm, "_done_after_last"}, done_cyc, last_act + 1);
    end
    chk({v.nm, "_wr_rd_excl"}, v_excl, 0);
    chk({v.nm, "_ready_in_write"}, v_wrrdy, 0);
    chk({v.nm, "_addr_hold"}, v_hold, 0);
    chk({v.nm, "_busy_after_done"}, busy_late, 0);
  endtask

  vec_t tbl[10];

  initial begin
    int ndone, nbusy;
    vec_t rv;
    tbl[0] = mk("load1",      1, 0,   5, 1, 0, 100, 0, 1, -1, 1, 0, 18);
    tbl[1] = mk("load_wrap",  1, 0, 127, 2, 0,  60, 0, 0, -1, 2, 0, -1);
    tbl[2] = mk("run_stall",  0, 0,  10, 3, 2, 100, 1, 0, -1, 0, 6, -1);
    tbl[3] = mk("run_plain",  0, 0,  10, 3, 1, 100, 0, 0, -1, 0, 3,  4);
    tbl[4] = mk("load_len0",  1, 0,  40, 0, 0, 100, 0, 0, -1, 0, 0,  1);
    tbl[5] = mk("run_len0",   0, 0,  40, 0, 5, 100, 0, 0, -1, 0, 0,  1);
    tbl[6] = mk("both_start", 0, 1,  20, 1, 3, 100, 0, 0, -1, 1, 0, 18);
    tbl[7] = mk("run_busy",   0, 0,  50, 4, 0, 100, 0, 0,  2, 0, 4,  5);
    tbl[8] = mk("run_wrap",   0, 0, 126, 3, 3, 100, 2, 0, -1, 0, 9, -1);
    tbl[9] = mk("load_busy",  1, 0,   0, 3, 0,  70, 0, 0,  5, 3, 0, -1);

    rst_n = 1'b0; in_load_start = 1'b0; in_run_start = 1'b0;
    in_cfg_base = '0; in_cfg_len = '0; in_cfg_repeat = '0;
    in_s_valid = 1'b0; in_s_data = '0; in_mac_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", out_s_ready, 0);
    chk("rst_wr_en",   out_wr_en, 0);
    chk("rst_rd_en",   out_rd_en, 0);
    chk("rst_busy",    out_busy, 0);
    chk("rst_done",    out_done, 0);
    chk("rst_wr_addr", out_wr_addr, 0);
    chk("rst_rd_addr", out_rd_addr, 0);
    chk("rst_wr_data", out_wr_data, 0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) do_op(tbl[i]);

    // asynchronous reset in the middle of a RUN
    @(posedge clk); #1;
    in_run_start = 1'b1; in_cfg_base = 7'd10; in_cfg_len = 7'd5; in_cfg_repeat = 8'd3; in_mac_ready = 1'b1;
    @(posedge clk); #1 in_run_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mrst_rd_before", out_rd_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_rd_async", out_rd_en, 0);
    chk("mrst_busy_async", out_busy, 0);
    chk("mrst_rd_addr", out_rd_addr, 0);
    @(negedge clk); #1 rst_n = 1'b1;
    ndone = 0; nbusy = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_done) ndone++;
      if (out_busy) nbusy++;
    end
    chk("mrst_no_done", ndone, 0);
    chk("mrst_idle", nbusy, 0);
    in_mac_ready = 1'b0;
    do_op(mk("load_after_rst", 1, 0, 33, 1, 0, 100, 0, 0, -1, 1, 0, 18));

    for (int r = 0; r < 6; r++) begin
      rv = mk($sformatf("rand%0d", r), 1'($urandom), 0, int'($urandom_range(127)),
              int'($urandom_range(1, 3)), int'($urandom_range(3)),
              int'($urandom_range(40, 100)), 2, 0, -1, -1, -1, -1);
      do_op(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
